// File: rtl/rcpa2_err_monitor_if.sv
// Sample/control/result bundle between a stimulus source and the approximate-adder error monitor.
interface rcpa2_err_monitor_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [N-1:0]     approx_sum;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic [N:0]       max_ed;
    logic [N+CNT_W:0] sum_ed;

    modport master (
        output start, num_samples, in_valid, a, b, approx_sum,
        input  in_ready, busy, done, err_count, max_ed, sum_ed
    );

    modport slave (
        input  start, num_samples, in_valid, a, b, approx_sum,
        output in_ready, busy, done, err_count, max_ed, sum_ed
    );
endinterface

// File: rtl/rcpa2_err_monitor.sv
// Measures error statistics (error count, max and sum of error distance) of an
// approximate N-bit adder over a run of num_samples accepted samples.
module rcpa2_err_monitor #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    rcpa2_err_monitor_if.slave  bus
);
    localparam int SW = N + 1 + CNT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, target_q, cnt_inc;
    logic [CNT_W-1:0] err_q;
    logic [N:0]       max_q;
    logic [SW-1:0]    sum_q;
    logic [N:0]       exact, approx, ed;
    logic             start_ok, accept, last;

    // The approximate adder has no carry-out, so its sum is compared zero-extended.
    assign exact    = {1'b0, bus.a} + {1'b0, bus.b};
    assign approx   = {1'b0, bus.approx_sum};
    assign ed       = (exact >= approx) ? (exact - approx) : (approx - exact);

    assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign accept   = bus.in_valid && (state_q == RUN);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign last     = (cnt_inc == target_q);

    always_comb begin
        // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = (bus.num_samples == '0) ? DONE : RUN;
            RUN:        if (accept && last) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A restart only clears; accumulation is impossible on that edge since accept needs RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            target_q <= '0;
            err_q    <= '0;
            max_q    <= '0;
            sum_q    <= '0;
        end else if (start_ok) begin
            cnt_q    <= '0;
            target_q <= bus.num_samples;
            err_q    <= '0;
            max_q    <= '0;
            sum_q    <= '0;
        end else if (accept) begin
            cnt_q <= cnt_inc;
            if (ed != '0)   err_q <= err_q + CNT_W'(1);
            if (ed > max_q) max_q <= ed;
            sum_q <= sum_q + SW'(ed);
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.err_count = err_q;
    assign bus.max_ed    = max_q;
    assign bus.sum_ed    = sum_q;
endmodule

// File: tb/tb_rcpa2_err_monitor.sv
// Self-checking bench for rcpa2_err_monitor: vector table, directed corner sequences, random runs vs. a model.
module tb_rcpa2_err_monitor;
    localparam int N     = 8;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rcpa2_err_monitor_if #(.N(N), .CNT_W(CNT_W)) ifc ();

    rcpa2_err_monitor #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] s;
        logic [N:0]   ed;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] ns);
        ifc.start       = 1'b1;
        ifc.num_samples = ns;
        step();
        ifc.start       = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] s);
        ifc.in_valid   = 1'b1;
        ifc.a          = a;
        ifc.b          = b;
        ifc.approx_sum = s;
        check("in_ready_at_send", 64'(ifc.in_ready), 64'd1);
        step();
        ifc.in_valid = 1'b0;
    endtask

    task automatic check_results(input string tag, input longint err, input longint mx, input longint sm);
        check({tag, "_err_count"}, 64'(ifc.err_count), 64'(err));
        check({tag, "_max_ed"},    64'(ifc.max_ed),    64'(mx));
        check({tag, "_sum_ed"},    64'(ifc.sum_ed),    64'(sm));
    endtask

    function automatic int ref_ed(input int a, input int b, input int s);
        int d;
        d = a + b - s;
        return (d < 0) ? -d : d;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ifc.start = 1'b0;
        ifc.num_samples = '0;
        ifc.in_valid = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        ifc.approx_sum = '0;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 9'h000};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFE, 9'h100};
        vecs[2] = '{8'hFF, 8'h01, 8'h00, 9'h100};
        vecs[3] = '{8'h0F, 8'h01, 8'h1F, 9'h00F};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 9'h0FF};
        vecs[5] = '{8'h00, 8'h00, 8'hFF, 9'h0FF};
        vecs[6] = '{8'h7F, 8'h01, 8'h80, 9'h000};
        vecs[7] = '{8'hAA, 8'h55, 8'hF0, 9'h00F};

        // Reset state
        #2;
        check("rst_busy", 64'(ifc.busy), 64'd0);
        check("rst_done", 64'(ifc.done), 64'd0);
        check("rst_in_ready", 64'(ifc.in_ready), 64'd0);
        check_results("rst", 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_after_release", 64'({ifc.busy, ifc.done}), 64'd0);

        // Single-sample runs from the vector table
        for (int i = 0; i < 8; i++) begin
            do_start(1);
            send(vecs[i].a, vecs[i].b, vecs[i].s);
            check("vec_done", 64'(ifc.done), 64'd1);
            check_results($sformatf("vec%0d", i), (vecs[i].ed != 0) ? 1 : 0, vecs[i].ed, vecs[i].ed);
        end

        // num_samples=1, carry-out lost
        do_start(1);
        check("s1_busy", 64'(ifc.busy), 64'd1);
        send(8'h80, 8'h80, 8'h00);
        check("s1_done", 64'(ifc.done), 64'd1);
        check("s1_in_ready_low", 64'(ifc.in_ready), 64'd0);
        check_results("s1", 1, 9'h100, 9'h100);

        // Three exact samples
        do_start(3);
        send(8'h12, 8'h34, 8'h46);
        send(8'hFF, 8'h00, 8'hFF);
        check("exact_not_done_early", 64'(ifc.done), 64'd0);
        send(8'h01, 8'h01, 8'h02);
        check("exact_done", 64'(ifc.done), 64'd1);
        check_results("exact", 0, 0, 0);

        // Four samples with gaps, ED = 3,0,7,1
        do_start(4);
        send(8'h10, 8'h10, 8'h23);
        step();
        send(8'h05, 8'h05, 8'h0A);
        step();
        step();
        check("gap_still_busy", 64'(ifc.busy), 64'd1);
        send(8'h20, 8'h20, 8'h39);
        step();
        send(8'h40, 8'h00, 8'h41);
        check("gap_done", 64'(ifc.done), 64'd1);
        check("gap_in_ready_low", 64'(ifc.in_ready), 64'd0);
        check_results("gap", 3, 7, 11);
        ifc.in_valid = 1'b1;
        ifc.a = 8'hFF;
        ifc.b = 8'hFF;
        ifc.approx_sum = 8'h00;
        step();
        step();
        ifc.in_valid = 1'b0;
        check_results("gap_hold", 3, 7, 11);
        check("gap_hold_done", 64'(ifc.done), 64'd1);

        // Zero-length run
        do_start(0);
        check("zero_done", 64'(ifc.done), 64'd1);
        check("zero_in_ready", 64'(ifc.in_ready), 64'd0);
        check_results("zero", 0, 0, 0);
        step();
        check("zero_in_ready_later", 64'(ifc.in_ready), 64'd0);

        // Asynchronous reset mid-run
        do_start(5);
        send(8'h01, 8'h01, 8'h00);
        send(8'h10, 8'h00, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(ifc.busy), 64'd0);
        check("arst_in_ready", 64'(ifc.in_ready), 64'd0);
        check_results("arst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("arst_idle", 64'({ifc.busy, ifc.done}), 64'd0);
        do_start(1);
        send(8'h01, 8'h01, 8'h00);
        check("arst_rerun_done", 64'(ifc.done), 64'd1);
        check_results("arst_rerun", 1, 2, 2);

        // start ignored in RUN; start + in_valid in DONE restarts only
        do_start(3);
        send(8'h01, 8'h00, 8'h00);
        ifc.start = 1'b1;
        ifc.num_samples = 16'd1;
        step();
        ifc.start = 1'b0;
        check("run_start_ignored", 64'(ifc.busy), 64'd1);
        send(8'h02, 8'h00, 8'h00);
        check("run_len_kept", 64'(ifc.busy), 64'd1);
        send(8'h03, 8'h00, 8'h00);
        check("run_len_done", 64'(ifc.done), 64'd1);
        check_results("run_start", 3, 3, 6);
        ifc.start = 1'b1;
        ifc.num_samples = 16'd2;
        ifc.in_valid = 1'b1;
        ifc.a = 8'h80;
        ifc.b = 8'h80;
        ifc.approx_sum = 8'h00;
        step();
        ifc.start = 1'b0;
        ifc.in_valid = 1'b0;
        check("restart_busy", 64'(ifc.busy), 64'd1);
        check_results("restart", 0, 0, 0);
        send(8'h04, 8'h00, 8'h00);
        send(8'h00, 8'h00, 8'h00);
        check("restart_done", 64'(ifc.done), 64'd1);
        check_results("restart_end", 1, 4, 4);

        // Random runs against the model
        for (int r = 0; r < 20; r++) begin
            int     ns;
            int     acc;
            int     cyc;
            longint m_err;
            longint m_max;
            longint m_sum;
            ns = int'($urandom_range(1, 12));
            acc = 0;
            cyc = 0;
            m_err = 0;
            m_max = 0;
            m_sum = 0;
            do_start(CNT_W'(ns));
            while (acc < ns && cyc < 200) begin
                int ea;
                int eb;
                int es;
                int d;
                logic v;
                v  = ($urandom_range(0, 2) != 0);
                ea = int'($urandom_range(0, 255));
                eb = int'($urandom_range(0, 255));
                es = ($urandom_range(0, 1) != 0) ? ((ea + eb) & 255) : int'($urandom_range(0, 255));
                ifc.in_valid = v;
                ifc.a = N'(ea);
                ifc.b = N'(eb);
                ifc.approx_sum = N'(es);
                check("rnd_in_ready", 64'(ifc.in_ready), 64'd1);
                step();
                if (v) begin
                    d = ref_ed(ea, eb, es);
                    acc++;
                    if (d != 0) m_err++;
                    if (d > m_max) m_max = d;
                    m_sum += d;
                end
                cyc++;
            end
            ifc.in_valid = 1'b0;
            check("rnd_bound", 64'(cyc < 200), 64'd1);
            check("rnd_done", 64'(ifc.done), 64'd1);
            check("rnd_in_ready_low", 64'(ifc.in_ready), 64'd0);
            check_results($sformatf("rnd%0d", r), m_err, m_max, m_sum);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rcpa2_err_monitor.md
RCPA2_ERR_MONITOR -- requirements
Module: rcpa2_err_monitor

Interface
REQ-001 SHALL have parameter N, default 8, operand width of the monitored approximate adder.
REQ-002 SHALL have parameter CNT_W, default 16, sample-counter and error-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a measurement run; honoured in IDLE and DONE only.
REQ-006 SHALL have port num_samples  input  CNT_W  samples per run; sampled when start is honoured.
REQ-007 SHALL have port in_valid  input  1  sample presented on a, b, approx_sum.
REQ-008 SHALL have port in_ready  output  1  monitor accepts a sample this cycle.
REQ-009 SHALL have port a  input  N  adder operand A.
REQ-010 SHALL have port b  input  N  adder operand B.
REQ-011 SHALL have port approx_sum  input  N  approximate adder output (no carry-out).
REQ-012 SHALL have port busy  output  1  high in RUN.
REQ-013 SHALL have port done  output  1  high in DONE; results valid.
REQ-014 SHALL have port err_count  output  CNT_W  accepted samples with nonzero error distance.
REQ-015 SHALL have port max_ed  output  N+1  largest error distance in the run.
REQ-016 SHALL have port sum_ed  output  N+1+CNT_W  sum of error distances in the run.

Function
REQ-017 SHALL compute exact = a + b at N+1 bits, zero-extend approx_sum to N+1 bits, ED = |exact - approx|, unsigned, N+1 bits.
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; busy=(RUN), done=(DONE), in_ready=(RUN), all decoded directly from state registers.
REQ-019 SHALL, on honoured start with num_samples != 0, clear err_count, max_ed, sum_ed and the sample counter, latch num_samples, and enter RUN on the same edge.
REQ-020 SHALL, on honoured start with num_samples == 0, clear all results and enter DONE directly.
REQ-021 SHALL accept a sample exactly on cycles with in_valid && in_ready; no other cycle updates the accumulators.
REQ-022 SHALL, on acceptance, update on that edge: sample counter +1; err_count +1 if ED != 0; max_ed = max(max_ed, ED); sum_ed += ED.
REQ-023 SHALL enter DONE on the edge that accepts the latched num_samples-th sample; in_ready low from the next cycle; that sample is included in the results.
REQ-024 SHALL hold DONE and all results stable until the next honoured start; in_valid in DONE or IDLE is ignored.
REQ-025 SHALL ignore start while in RUN; num_samples changes during RUN have no effect.
REQ-026 SHALL size sum_ed so it never overflows: (2^CNT_W - 1) * (2^(N+1) - 1) fits N+1+CNT_W bits; no saturation logic.
REQ-027 SHALL, when start and in_valid coincide in DONE, perform the restart only, with no accumulation on that edge.

Reset
REQ-028 SHALL, while rst_n is low, immediately force state IDLE, busy=0, done=0, in_ready=0, and all counters/results to 0, independent of clk.
REQ-029 SHALL abandon any in-progress run on reset; after release, stay in IDLE until start.

Verification
REQ-030 SHALL cover N=8, num_samples=1: a=0x80, b=0x80, approx_sum=0x00 -> done next cycle, err_count=1, max_ed=0x100, sum_ed=0x100.
REQ-031 SHALL cover num_samples=3 exact samples (0x12+0x34->0x46, 0xFF+0x00->0xFF, 0x01+0x01->0x02) -> err_count=0, max_ed=0, sum_ed=0.
REQ-032 SHALL cover num_samples=4 with in_valid gaps and errors ED=3,0,7,1 -> exactly 4 acceptances, err_count=3, max_ed=7, sum_ed=11, in_ready low after 4th.
REQ-033 SHALL cover start with num_samples=0 -> DONE next cycle, all results 0, in_ready never high.
REQ-034 SHALL cover rst_n low mid-RUN after 2 of 5 samples -> outputs 0 asynchronously, IDLE after release; new run of 1 sample reports only that sample.
REQ-035 SHALL cover start pulse during RUN and start+in_valid in DONE -> run length unchanged; restart clears results, no sample accumulated on restart edge.
